// File: rtl/ram8_seq_pkg.sv
// ram8_seq_pkg: shared constants and the controller state type for the
// RAM8 sequencer. The word width, depth and address width are fixed here,
// not passed as parameters.
package ram8_seq_pkg;

    localparam int WIDTH = 16;  // data word width
    localparam int DEPTH = 8;   // number of RAM8 words
    localparam int AW    = 3;   // RAM8 address width
    localparam int CW    = 4;   // occupancy counter width (0..DEPTH)

    // Occupancy at which the buffer reports full.
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,  // accepts writes, clear and rd_start
        FETCH = 2'd1,  // RAM8 is addressed by rd_ptr; capture ram_out
        SEND  = 2'd2   // rd_data is presented until the consumer takes it
    } state_e;

endpackage : ram8_seq_pkg

// File: rtl/ram8_seq.sv
// ram8_seq: sequencer that fills an external 8x16 RAM8 from a valid/ready
// write stream. On request it reads all stored words back in order, from
// address 0 upward, over a valid/ready read stream. Readback does not
// remove the words from the buffer.
//
// Ports
//   clk       in   sole clock; all state changes on the rising edge
//   reset     in   synchronous, active-high reset
//   clear     in   empties the buffer (count, wr_ptr := 0); honoured in IDLE
//   wr_valid  in   upstream word available
//   wr_data   in   upstream word
//   wr_ready  out  a word is accepted this cycle
//   rd_start  in   request readback of all stored words
//   rd_valid  out  rd_data holds a readback word
//   rd_data   out  registered readback word
//   rd_ready  in   downstream consumes rd_data
//   ram_addr  out  RAM8 address (wr_ptr in IDLE, rd_ptr otherwise)
//   ram_in    out  RAM8 write data (always wr_data)
//   ram_load  out  RAM8 write enable (write handshake only)
//   ram_out   in   RAM8 read data, combinational from ram_addr
//   count     out  number of stored words, 0..8
//   busy      out  high whenever the controller is not IDLE
module ram8_seq
    import ram8_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             wr_valid,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ready,
    input  logic             rd_start,
    output logic             rd_valid,
    output logic [WIDTH-1:0] rd_data,
    input  logic             rd_ready,
    output logic [AW-1:0]    ram_addr,
    output logic [WIDTH-1:0] ram_in,
    output logic             ram_load,
    input  logic [WIDTH-1:0] ram_out,
    output logic [CW-1:0]    count,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    logic             wr_fire;
    logic             rd_last;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // The word in SEND is the last one when rd_ptr has reached count-1.
    assign rd_last = ({1'b0, rd_ptr_q} == (count_q - CW'(1)));

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a hold-value default first, so
    // no branch can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        unique case (state_q)
            IDLE: begin
                // Priority: clear, then a write, then a read request.
                if (clear) begin
                    count_d  = '0;
                    wr_ptr_d = '0;
                end else if (wr_fire) begin
                    // wr_ptr wraps 7->0 on the eighth write, then stays
                    // at 0 because the buffer is full.
                    wr_ptr_d = wr_ptr_q + AW'(1);
                    count_d  = count_q + CW'(1);
                end else if (rd_start && (count_q != '0)) begin
                    rd_ptr_d = '0;
                    state_d  = FETCH;
                end
            end

            FETCH: begin
                rd_data_d  = ram_out;
                rd_valid_d = 1'b1;
                state_d    = SEND;
            end

            SEND: begin
                if (rd_valid_q && rd_ready) begin
                    rd_valid_d = 1'b0;
                    if (rd_last) begin
                        state_d = IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        state_d  = FETCH;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                rd_valid_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        wr_ready = (state_q == IDLE) && (count_q < FULL_COUNT) && !clear;
        wr_fire  = wr_valid && wr_ready;
        ram_load = wr_fire;
        ram_in   = wr_data;
        ram_addr = (state_q == IDLE) ? wr_ptr_q : rd_ptr_q;
        busy     = (state_q != IDLE);
        rd_valid = rd_valid_q;
        rd_data  = rd_data_q;
        count    = count_q;
    end

endmodule : ram8_seq
